touch_bounce_gen: RTL and testbench
===================================

TOUCH_BOUNCE_GEN -- requirements
Module: touch_bounce_gen

Purpose: synthesizable emulator that drives a bouncing touch/button waveform into top_LEDctrl for on-board self-test.

Interface
REQ-001 SHALL have parameter count_max, 20 bits, default 20'd10; the debounce count of the consuming receiver.
REQ-002 SHALL have parameter BOUNCE_W, integer, default 3; width of the random bounce-segment length.
REQ-003 SHALL have parameter SEED, 16 bits, default 16'hACE1; the LFSR reset value.
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request one press/release transaction.
REQ-007 abort  input  1  synchronous cancel of the current transaction.
REQ-008 hold_cycles  input  20  stable-press duration in clk cycles.
REQ-009 bounce_cnt  input  4  number of bounce pairs on press and on release.
REQ-010 touch  output  1  emulated button level (1 = pressed).
REQ-011 busy  output  1  high while a transaction is in progress.
REQ-012 done  output  1  one-cycle pulse at normal transaction completion.

Function
REQ-013 The FSM SHALL have states IDLE, PRESS_BOUNCE, HOLD, RELEASE_BOUNCE, SETTLE and DONE.
REQ-014 start SHALL be accepted only in IDLE; the block latches hold_cycles and bounce_cnt in the accept cycle T; start in any other state is ignored.
REQ-015 touch SHALL be 1 from cycle T+1, and busy SHALL be high from T+1 through the DONE cycle inclusive.
REQ-016 PRESS_BOUNCE: touch starts at 1 and toggles after each segment, for 2*bounce_cnt segments, ending at 1.
REQ-017 Each segment SHALL last LFSR[BOUNCE_W-1:0]+1 cycles (1..2^BOUNCE_W); the LFSR advances exactly once per segment boundary.
REQ-018 HOLD: touch = 1 for H = max(hold_cycles, count_max+2) cycles; widths use a 21-bit compare so there is no overflow.
REQ-019 RELEASE_BOUNCE: touch starts at 0 and toggles per segment, for 2*bounce_cnt segments, ending at 0.
REQ-020 SETTLE: touch = 0 for count_max+2 cycles; the FSM then enters DONE, pulses done once, and returns to IDLE the next cycle.
REQ-021 bounce_cnt = 0 SHALL skip PRESS_BOUNCE (T+1 is the first HOLD cycle) and RELEASE_BOUNCE (SETTLE directly after HOLD).
REQ-022 The number of touch rising edges per transaction SHALL equal 2*bounce_cnt+1.
REQ-023 LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1; a SEED of 0 is replaced by 16'h0001.
REQ-024 abort, in any non-IDLE state, SHALL drive touch = 0 and busy = 0 and enter IDLE the next cycle, with no done pulse.
REQ-025 abort in IDLE SHALL be a no-op.
REQ-026 When start and abort are both high in IDLE, abort SHALL win and the start is dropped.
REQ-027 A start asserted in the DONE cycle SHALL be ignored; the earliest accept is the first IDLE cycle.

Reset
REQ-028 reset SHALL override all inputs, including mid-transaction, and take effect at the next clock edge.
REQ-029 In that cycle reset SHALL set state = IDLE, touch = 0, busy = 0, done = 0, all counters = 0 and LFSR = SEED.

Structure
REQ-030 Package touch_pkg SHALL hold:
- the FSM state enum;
- the LFSR tap constant 16'hB400;
- the helper constant/function for count_max+2.
REQ-031 The LFSR SHALL be the one sub-module, lfsr16, with ports clk, reset, adv, seed, q.
REQ-032 There SHALL be one segment/duration down-counter (21 bits), shared across states.

Verification
REQ-033 count_max=10, bounce_cnt=0, hold=50, start at T:
- touch high on T+1..T+50, low from T+51;
- done high only at T+63;
- busy low at T+64.
REQ-034 hold=3, bounce_cnt=0 -> touch high for exactly 12 cycles (clamped to count_max+2).
REQ-035 bounce_cnt=2, hold=20:
- exactly 5 touch rising edges;
- every segment 1..8 cycles;
- stable high ≥ 20 cycles;
- final level 0 before done.
REQ-036 Robustness (the three cases are checked separately):
- start pulsed during HOLD -> no second transaction and exactly one done;
- abort during HOLD -> touch 0, busy 0 next cycle, done never pulses;
- reset mid-PRESS_BOUNCE -> all outputs 0 next cycle, and LFSR = SEED.
REQ-037 touch_bounce_gen driving top_LEDctrl (count_max=10), bounce_cnt=3:
- two transactions separated by idle -> led advances exactly two steps;
- no extra step from bounce edges.

Source files
------------

// File: rtl/touch_pkg.sv
// Shared types and constants for the touch/button bounce emulator.
// Holds the FSM state encoding, the LFSR feedback taps and the
// duration helpers used to size the settle and hold intervals.
package touch_pkg;

    typedef enum logic [2:0] {
        IDLE           = 3'd0,
        PRESS_BOUNCE   = 3'd1,
        HOLD           = 3'd2,
        RELEASE_BOUNCE = 3'd3,
        SETTLE         = 3'd4,
        DONE           = 3'd5
    } state_t;

    // Galois taps for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form).
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Settle time: receiver debounce count plus two cycles of margin.
    // Computed in 21 bits so count_max = 2^20-1 cannot wrap.
    function automatic logic [20:0] settle_len(input logic [19:0] cm);
        return {1'b0, cm} + 21'd2;
    endfunction

    // Stable-press time: requested hold, but never shorter than the settle time.
    function automatic logic [20:0] hold_len(input logic [19:0] h, input logic [19:0] cm);
        logic [20:0] s;
        s = settle_len(cm);
        return ({1'b0, h} > s) ? {1'b0, h} : s;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR that supplies pseudo-random bounce segment lengths.
// Ports: clk, reset (sync, active-high, loads seed), adv (step once), seed, q (current state).
// Latency: q updates on the edge after adv; no backpressure, adv is a plain step strobe.
module lfsr16
    import touch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        adv,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] q_q;
    logic [15:0] q_d;
    logic [15:0] seed_nz;

    // An all-zero state would lock the LFSR up, so substitute 1.
    assign seed_nz = (seed == 16'h0000) ? 16'h0001 : seed;

    always_comb begin
        q_d = q_q;
        if (adv) begin
            q_d = (q_q >> 1) ^ (q_q[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= seed_nz;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/touch_bounce_gen.sv
// Emulates a bouncing button press/release for on-board self-test of a debounce receiver.
// Latency: touch rises the cycle after start is accepted; done pulses in the cycle before busy drops.
// Backpressure: none; start is only taken in IDLE, otherwise dropped. abort cancels at once.
// Ports: clk, reset (sync active-high), start, abort, hold_cycles[19:0], bounce_cnt[3:0]
//        -> touch (button level), busy (transaction in progress), done (completion pulse).
module touch_bounce_gen
    import touch_pkg::*;
#(
    parameter logic [19:0] count_max = 20'd10,
    parameter int          BOUNCE_W  = 3,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [19:0] hold_cycles,
    input  logic [3:0]  bounce_cnt,
    output logic        touch,
    output logic        busy,
    output logic        done
);

    localparam logic [20:0] SETTLE_LEN = settle_len(count_max);

    state_t      state_q, state_d;
    logic [20:0] cnt_q, cnt_d;      // shared segment/duration down-counter
    logic [4:0]  seg_q, seg_d;      // bounce segments still to run after the current one
    logic        touch_q, touch_d;
    logic [19:0] hold_q, hold_d;
    logic [3:0]  bnc_q, bnc_d;
    logic        lfsr_adv;
    logic [15:0] lfsr_q;
    logic [20:0] seg_len;
    logic        lfsr_unused;

    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .adv   (lfsr_adv),
        .seed  (SEED),
        .q     (lfsr_q)
    );

    // Counter holds "cycles remaining minus one", so a load of L gives L+1 cycles.
    assign seg_len     = 21'(lfsr_q[BOUNCE_W-1:0]);
    assign lfsr_unused = ^lfsr_q[15:BOUNCE_W];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        seg_d    = seg_q;
        touch_d  = touch_q;
        hold_d   = hold_q;
        bnc_d    = bnc_q;
        lfsr_adv = 1'b0;

        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            cnt_d   = '0;
            seg_d   = '0;
            touch_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // abort beats a simultaneous start.
                    if (start && !abort) begin
                        hold_d  = hold_cycles;
                        bnc_d   = bounce_cnt;
                        touch_d = 1'b1;
                        if (bounce_cnt != 4'd0) begin
                            state_d  = PRESS_BOUNCE;
                            cnt_d    = seg_len;
                            lfsr_adv = 1'b1;
                            seg_d    = {bounce_cnt, 1'b0} - 5'd1;
                        end else begin
                            state_d = HOLD;
                            cnt_d   = hold_len(hold_cycles, count_max) - 21'd1;
                        end
                    end
                end
                PRESS_BOUNCE: begin
                    if (cnt_q != 21'd0) begin
                        cnt_d = cnt_q - 21'd1;
                    end else if (seg_q != 5'd0) begin
                        touch_d  = ~touch_q;
                        cnt_d    = seg_len;
                        lfsr_adv = 1'b1;
                        seg_d    = seg_q - 5'd1;
                    end else begin
                        // Last press segment is low; toggling lands on the stable press.
                        state_d = HOLD;
                        touch_d = 1'b1;
                        cnt_d   = hold_len(hold_q, count_max) - 21'd1;
                    end
                end
                HOLD: begin
                    if (cnt_q != 21'd0) begin
                        cnt_d = cnt_q - 21'd1;
                    end else if (bnc_q != 4'd0) begin
                        state_d  = RELEASE_BOUNCE;
                        touch_d  = 1'b0;
                        cnt_d    = seg_len;
                        lfsr_adv = 1'b1;
                        seg_d    = {bnc_q, 1'b0} - 5'd1;
                    end else begin
                        state_d = SETTLE;
                        touch_d = 1'b0;
                        cnt_d   = SETTLE_LEN - 21'd1;
                    end
                end
                RELEASE_BOUNCE: begin
                    if (cnt_q != 21'd0) begin
                        cnt_d = cnt_q - 21'd1;
                    end else if (seg_q != 5'd0) begin
                        touch_d  = ~touch_q;
                        cnt_d    = seg_len;
                        lfsr_adv = 1'b1;
                        seg_d    = seg_q - 5'd1;
                    end else begin
                        // Last release segment is high; toggling lands on the released level.
                        state_d = SETTLE;
                        touch_d = 1'b0;
                        cnt_d   = SETTLE_LEN - 21'd1;
                    end
                end
                SETTLE: begin
                    if (cnt_q != 21'd0) begin
                        cnt_d = cnt_q - 21'd1;
                    end else begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    // Unconditional return: a start seen here is not taken.
                    state_d = IDLE;
                    cnt_d   = '0;
                    seg_d   = '0;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    seg_d   = '0;
                    touch_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            seg_q   <= '0;
            touch_q <= 1'b0;
            hold_q  <= '0;
            bnc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seg_q   <= seg_d;
            touch_q <= touch_d;
            hold_q  <= hold_d;
            bnc_q   <= bnc_d;
        end
    end

    assign touch = touch_q;
    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);

endmodule

// File: tb/tb_touch_bounce_gen.sv
// Self-checking bench for touch_bounce_gen: scoreboarded transactions, timing of the
// stable press/settle, bounce shape, start/abort/reset robustness, and a debounce
// receiver model counting LED steps.
module tb_touch_bounce_gen;

    localparam logic [19:0] CM     = 20'd10;
    localparam int          CMI    = 10;
    localparam int          CM2    = CMI + 2;
    localparam int          BW     = 3;
    localparam logic [15:0] SEED_V = 16'hACE1;

    logic        clk = 1'b0;
    logic        reset, start, abort;
    logic [19:0] hold_cycles;
    logic [3:0]  bounce_cnt;
    logic        touch, busy, done;

    always #5 clk = ~clk;

    touch_bounce_gen #(
        .count_max (CM),
        .BOUNCE_W  (BW),
        .SEED      (SEED_V)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .hold_cycles (hold_cycles),
        .bounce_cnt  (bounce_cnt),
        .touch       (touch),
        .busy        (busy),
        .done        (done)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    typedef struct {
        int t_acc;
        int bnc;
        int h;
    } exp_t;
    exp_t sb_q[$];
    exp_t e;

    logic prev_touch = 1'b0, prev_busy = 1'b0, prev_done = 1'b0;
    int   rises, runs, long_runs, max_high, run_len, first_cyc;
    int   done_cnt = 0;

    always @(negedge clk) begin
        if (prev_done) check_eq("busy_after_done", busy, 0);
        if (busy) begin
            if (!prev_busy) begin
                rises = 0; runs = 0; long_runs = 0; max_high = 0;
                run_len = 1; first_cyc = cyc;
            end else if (touch == prev_touch) begin
                run_len++;
            end else begin
                runs++;
                if (run_len > 8) long_runs++;
                if (prev_touch && run_len > max_high) max_high = run_len;
                run_len = 1;
            end
            if (touch && !prev_touch) rises++;
        end
        if (done) begin
            done_cnt++;
            check_eq("done_expected", sb_q.size() > 0, 1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check_eq("final_touch", touch, 0);
                check_eq("rises", rises, 2 * e.bnc + 1);
                check_eq("runs", runs + 1, 4 * e.bnc + 2);
                check_eq("long_runs", long_runs + ((run_len > 8) ? 1 : 0), 2);
                if (e.bnc == 0) begin
                    check_eq("done_cyc", cyc, e.t_acc + e.h + CM2 + 1);
                    check_eq("first_busy", first_cyc, e.t_acc + 1);
                    check_eq("high_len", max_high, e.h);
                end else begin
                    check_eq("stable_high_ge_h", max_high >= e.h, 1);
                end
            end
        end
        prev_touch = touch;
        prev_busy  = busy;
        prev_done  = done;
    end

    // ---------------- debounce receiver model (LED stepper) ----------------
    int   led = 0;
    int   deb_cnt = 0;
    logic deb_lvl = 1'b0;
    always @(negedge clk) begin
        if (touch != deb_lvl) begin
            deb_cnt++;
            if (deb_cnt >= CMI) begin
                deb_lvl = touch;
                deb_cnt = 0;
                if (touch) led++;
            end
        end else begin
            deb_cnt = 0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_start(input int h, input int b, input bit expect_ok, output int t);
        hold_cycles = 20'(h);
        bounce_cnt  = 4'(b);
        start       = 1'b1;
        t           = cyc;
        if (expect_ok) sb_q.push_back('{t, b, (h > CM2) ? h : CM2});
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        while (busy && n < max_cyc) begin
            tick();
            n++;
        end
        check_eq("idle_timeout", busy, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t, t2, d0, led0, lvl, seg_left, segs_done;
        int          lv[1:6];
        logic [15:0] m;

        reset = 1'b1; start = 1'b0; abort = 1'b0;
        hold_cycles = '0; bounce_cnt = '0;
        repeat (3) tick();
        check_eq("rst_touch", touch, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_lfsr", dut.u_lfsr.q, SEED_V);
        reset = 1'b0;
        tick();

        // Basic press: hold=50, no bounce, then a start in the DONE cycle.
        do_start(50, 0, 1, t);
        check_eq("touch_t1", touch, 1);
        check_eq("busy_t1", busy, 1);
        repeat (49) tick();
        check_eq("touch_t50", touch, 1);
        tick();
        check_eq("touch_t51", touch, 0);
        repeat (12) tick();
        check_eq("done_t63", done, 1);
        hold_cycles = 20'd3; bounce_cnt = 4'd0; start = 1'b1;
        tick();
        check_eq("start_in_done_ignored", busy, 0);
        // Start still high in the first IDLE cycle: accepted; hold=3 clamps to 12.
        do_start(3, 0, 1, t2);
        check_eq("busy_after_idle_start", busy, 1);
        wait_idle(200);

        // Reset in the middle of the press bounce.
        do_start(20, 2, 0, t);
        tick();
        reset = 1'b1;
        tick();
        check_eq("midrst_touch", touch, 0);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_done", done, 0);
        check_eq("midrst_lfsr", dut.u_lfsr.q, SEED_V);
        reset = 1'b0;
        tick();

        // Bounce transaction from a freshly seeded LFSR: predict the first segments.
        m = SEED_V; lvl = 1; segs_done = 0;
        seg_left = int'(m[2:0]) + 1; m = lfsr_next(m);
        for (int k = 1; k <= 6; k++) begin
            lv[k] = lvl;
            seg_left--;
            if (seg_left == 0) begin
                segs_done++;
                lvl = 1 - lvl;
                if (segs_done < 4) begin
                    seg_left = int'(m[2:0]) + 1;
                    m = lfsr_next(m);
                end else begin
                    seg_left = 1000;
                end
            end
        end
        do_start(20, 2, 1, t);
        for (int k = 1; k <= 6; k++) begin
            check_eq($sformatf("press_seg_lvl%0d", k), touch, lv[k]);
            tick();
        end
        wait_idle(400);

        // Start pulsed during HOLD must not start a second transaction.
        d0 = done_cnt;
        do_start(40, 0, 1, t);
        repeat (20) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle(200);
        repeat (5) tick();
        check_eq("one_done_hold_start", done_cnt - d0, 1);
        check_eq("idle_after_hold_start", busy, 0);

        // Abort during HOLD.
        d0 = done_cnt;
        do_start(40, 0, 0, t);
        repeat (10) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("abort_touch", touch, 0);
        check_eq("abort_busy", busy, 0);
        repeat (70) tick();
        check_eq("abort_no_done", done_cnt - d0, 0);

        // Abort and start together in IDLE: abort wins.
        start = 1'b1; abort = 1'b1; hold_cycles = 20'd20; bounce_cnt = 4'd1;
        tick();
        start = 1'b0; abort = 1'b0;
        check_eq("abort_beats_start", busy, 0);
        tick();

        // Two bounced transactions into the receiver model: exactly two LED steps.
        led0 = led;
        do_start(15, 3, 1, t);
        wait_idle(400);
        repeat (20) tick();
        do_start(15, 3, 1, t);
        wait_idle(400);
        repeat (20) tick();
        check_eq("led_steps", led - led0, 2);
        check_eq("sb_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
